// File: rtl/adc_sample_scheduler_if.sv
// Bundle of config, sampler-handshake and status signals between the
// AXI-Lite register block, the ADC sample scheduler and the sampler.
// The master side drives configuration and the sampler busy flag. The
// slave side is the scheduler itself.
interface adc_sample_scheduler_if #(
  parameter int LEN_W = 32,
  parameter int FRM_W = 16
);
  // Configuration from software
  logic             cfg_start;
  logic             cfg_abort;
  logic [LEN_W-1:0] cfg_frame_len;
  logic [FRM_W-1:0] cfg_frame_num;
  logic [LEN_W-1:0] cfg_gap;

  // Sampler handshake
  logic [LEN_W-1:0] sample_len;
  logic             sample_start;
  logic             st_clr;

  // Status back to software
  logic             busy;
  logic [FRM_W-1:0] frame_cnt;
  logic             done_irq;
  logic             err_cfg;
  logic             err_timeout;
  logic             aborted;

  modport master (
    output cfg_start, cfg_abort, cfg_frame_len, cfg_frame_num, cfg_gap,
    output st_clr,
    input  sample_len, sample_start,
    input  busy, frame_cnt, done_irq, err_cfg, err_timeout, aborted
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_frame_len, cfg_frame_num, cfg_gap,
    input  st_clr,
    output sample_len, sample_start,
    output busy, frame_cnt, done_irq, err_cfg, err_timeout, aborted
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Multi-frame capture sequencer for the ADC sample engine.
// Requests one frame at a time from the sampler (sample_start level).
// Tracks each frame through the sampler busy flag st_clr. Inserts the
// programmed idle gap between frames and reports completion, abort and
// request timeout. Every output comes straight from a register.
module adc_sample_scheduler #(
  parameter int LEN_W       = 32,
  parameter int FRM_W       = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   adc_clk,
  input  logic                   adc_rst,
  adc_sample_scheduler_if.slave  bus
);

  localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RUN,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_sample_len;
  logic [FRM_W-1:0] r_frame_num;
  logic [LEN_W-1:0] r_gap;
  logic [ACK_W-1:0] r_ack_cnt;
  logic [LEN_W-1:0] r_gap_cnt;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_sample_start;
  logic             r_busy;
  logic             r_done_irq;
  logic             r_err_cfg;
  logic             r_err_timeout;
  logic             r_aborted;
  // DRAIN bookkeeping: r_drain_min marks that the first DRAIN cycle has passed.
  // r_frame_live marks that a frame was seen in flight and must be counted.
  logic             r_drain_min;
  logic             r_frame_live;

  logic [FRM_W-1:0] w_cnt_inc;
  logic             w_last_frame;
  logic             w_ack_expired;
  logic             w_gap_done;

  // Frame counter wraps naturally. A frame_num of 0 never matches, which gives continuous mode.
  assign w_cnt_inc     = r_frame_cnt + FRM_W'(1);
  assign w_last_frame  = (r_frame_num != '0) && (w_cnt_inc == r_frame_num);
  assign w_ack_expired = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
  // Only evaluated in GAP, where r_gap is known to be non-zero
  assign w_gap_done    = (r_gap_cnt == (r_gap - LEN_W'(1)));

  // Single state machine; all outputs registered alongside the state
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      r_state        <= S_IDLE;
      r_sample_len   <= '0;
      r_frame_num    <= '0;
      r_gap          <= '0;
      r_ack_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_frame_cnt    <= '0;
      r_sample_start <= 1'b0;
      r_busy         <= 1'b0;
      r_done_irq     <= 1'b0;
      r_err_cfg      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_aborted      <= 1'b0;
      r_drain_min    <= 1'b0;
      r_frame_live   <= 1'b0;
    end else begin
      r_done_irq <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Abort is meaningless here; start wins even if both arrive together
          if (bus.cfg_start) begin
            if (bus.cfg_frame_len == '0) begin
              r_err_cfg <= 1'b1;
            end else begin
              r_sample_len   <= bus.cfg_frame_len;
              r_frame_num    <= bus.cfg_frame_num;
              r_gap          <= bus.cfg_gap;
              r_frame_cnt    <= '0;
              r_err_cfg      <= 1'b0;
              r_err_timeout  <= 1'b0;
              r_aborted      <= 1'b0;
              r_ack_cnt      <= '0;
              r_sample_start <= 1'b1;
              r_busy         <= 1'b1;
              r_state        <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus.cfg_abort) begin
            // The sampler may already have taken the request, so let it settle in DRAIN
            r_sample_start <= 1'b0;
            r_ack_cnt      <= '0;
            r_drain_min    <= 1'b0;
            r_frame_live   <= bus.st_clr;
            r_state        <= S_DRAIN;
          end else if (bus.st_clr) begin
            r_sample_start <= 1'b0;
            r_ack_cnt      <= '0;
            r_state        <= S_RUN;
          end else if (w_ack_expired) begin
            r_err_timeout  <= 1'b1;
            r_sample_start <= 1'b0;
            r_ack_cnt      <= '0;
            r_busy         <= 1'b0;
            r_done_irq     <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + ACK_W'(1);
          end
        end

        S_RUN: begin
          if (bus.st_clr) begin
            // A frame in flight cannot be cut short; wait for it in DRAIN
            if (bus.cfg_abort) begin
              r_drain_min  <= 1'b0;
              r_frame_live <= 1'b1;
              r_state      <= S_DRAIN;
            end
          end else begin
            r_frame_cnt <= w_cnt_inc;
            if (bus.cfg_abort) begin
              r_aborted  <= 1'b1;
              r_busy     <= 1'b0;
              r_done_irq <= 1'b1;
              r_state    <= S_IDLE;
            end else if (w_last_frame) begin
              r_busy     <= 1'b0;
              r_done_irq <= 1'b1;
              r_state    <= S_IDLE;
            end else if (r_gap == '0) begin
              r_ack_cnt      <= '0;
              r_sample_start <= 1'b1;
              r_state        <= S_REQ;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (bus.cfg_abort) begin
            r_aborted  <= 1'b1;
            r_busy     <= 1'b0;
            r_done_irq <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_gap_done) begin
            r_ack_cnt      <= '0;
            r_sample_start <= 1'b1;
            r_state        <= S_REQ;
          end else begin
            r_gap_cnt <= r_gap_cnt + LEN_W'(1);
          end
        end

        S_DRAIN: begin
          // Hold at least two cycles so a late-latched request becomes visible on st_clr
          r_drain_min <= 1'b1;
          if (bus.st_clr) begin
            r_frame_live <= 1'b1;
          end else if (r_drain_min) begin
            if (r_frame_live) begin
              r_frame_cnt <= w_cnt_inc;
            end
            r_frame_live <= 1'b0;
            r_aborted    <= 1'b1;
            r_busy       <= 1'b0;
            r_done_irq   <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_sample_start <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sample_len   = r_sample_len;
  assign bus.sample_start = r_sample_start;
  assign bus.busy         = r_busy;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.done_irq     = r_done_irq;
  assign bus.err_cfg      = r_err_cfg;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.aborted      = r_aborted;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: behavioural sampler model plus a scoreboard
// of expected end-of-run status. The status is checked on every done_irq.
module tb_adc_sample_scheduler;

  logic adc_clk;
  logic adc_rst;

  adc_sample_scheduler_if bus ();

  adc_sample_scheduler #(
    .LEN_W       (32),
    .FRM_W       (16),
    .ACK_TIMEOUT (1024)
  ) dut (
    .adc_clk (adc_clk),
    .adc_rst (adc_rst),
    .bus     (bus)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  typedef struct {
    int   frame_cnt;
    logic err_cfg;
    logic err_timeout;
    logic aborted;
  } exp_t;

  exp_t        exp_q[$];
  int          rise_log[$];
  int          fall_log[$];
  int          fc_log[$];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          cyc        = 0;
  int          done_cnt   = 0;
  int          done_cyc   = 0;
  int          ss_high_cnt = 0;
  int          start_cyc  = 0;
  int          samp_mode  = 0;   // 0: normal sampler, 1: never acknowledges
  int          samp_len   = 8;   // cycles st_clr stays high per frame
  int          samp_hold  = 0;
  logic        prev_ss    = 1'b0;
  logic [15:0] prev_fc    = '0;

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(posedge adc_clk) cyc <= cyc + 1;

  // Monitor, then sampler model, on the falling edge
  always @(negedge adc_clk) begin
    exp_t e;
    if (bus.sample_start) ss_high_cnt++;
    if (bus.sample_start && !prev_ss) rise_log.push_back(cyc);
    if (bus.frame_cnt != prev_fc) fc_log.push_back(int'(bus.frame_cnt));
    prev_ss = bus.sample_start;
    prev_fc = bus.frame_cnt;
    if (bus.done_irq === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      $display("done_irq @%0d: frame_cnt=%0d err_cfg=%0d err_timeout=%0d aborted=%0d busy=%0d",
               cyc, bus.frame_cnt, bus.err_cfg, bus.err_timeout, bus.aborted, bus.busy);
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("done_frame_cnt", bus.frame_cnt, e.frame_cnt);
        check_val("done_err_cfg", bus.err_cfg, e.err_cfg);
        check_val("done_err_timeout", bus.err_timeout, e.err_timeout);
        check_val("done_aborted", bus.aborted, e.aborted);
        check_val("done_busy", bus.busy, 0);
      end
    end

    if (adc_rst) begin
      bus.st_clr = 1'b0;
      samp_hold  = 0;
    end else if (samp_mode == 0) begin
      if (bus.st_clr) begin
        if (samp_hold <= 1) begin
          bus.st_clr = 1'b0;
          fall_log.push_back(cyc);
        end else begin
          samp_hold--;
        end
      end else if (bus.sample_start) begin
        bus.st_clr = 1'b1;
        samp_hold  = samp_len;
      end
    end
  end

  task automatic push_exp(input int fc, input logic ec, input logic et, input logic ab);
    exp_t e;
    e.frame_cnt = fc; e.err_cfg = ec; e.err_timeout = et; e.aborted = ab;
    exp_q.push_back(e);
  endtask

  task automatic clear_logs();
    rise_log.delete();
    fall_log.delete();
    fc_log.delete();
    ss_high_cnt = 0;
  endtask

  task automatic start_run(input logic [31:0] len, input logic [15:0] num, input logic [31:0] gap);
    @(negedge adc_clk);
    bus.cfg_frame_len = len;
    bus.cfg_frame_num = num;
    bus.cfg_gap       = gap;
    bus.cfg_start     = 1'b1;
    start_cyc         = cyc;
    @(negedge adc_clk);
    bus.cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge adc_clk);
      n++;
    end
    @(negedge adc_clk);
    check_val("done_count", done_cnt, target);
  endtask

  task automatic wait_falls(input int target, input int budget);
    int n = 0;
    while (fall_log.size() < target && n < budget) begin
      @(posedge adc_clk);
      n++;
    end
    check_val("falls_reached", fall_log.size(), target);
  endtask

  initial begin
    int d0;
    int n;
    bus.cfg_start     = 1'b0;
    bus.cfg_abort     = 1'b0;
    bus.cfg_frame_len = '0;
    bus.cfg_frame_num = '0;
    bus.cfg_gap       = '0;
    adc_rst           = 1'b1;
    repeat (3) @(negedge adc_clk);

    // Reset state
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_sample_start", bus.sample_start, 0);
    check_val("rst_sample_len", bus.sample_len, 0);
    check_val("rst_frame_cnt", bus.frame_cnt, 0);
    check_val("rst_done_irq", bus.done_irq, 0);
    check_val("rst_err_cfg", bus.err_cfg, 0);
    check_val("rst_err_timeout", bus.err_timeout, 0);
    check_val("rst_aborted", bus.aborted, 0);
    adc_rst = 1'b0;
    repeat (2) @(negedge adc_clk);

    // Three back-to-back frames, no gap
    clear_logs();
    samp_len = 128;
    push_exp(3, 1'b0, 1'b0, 1'b0);
    start_run(32'd16, 16'd3, 32'd0);
    check_val("t1_sample_len", bus.sample_len, 16);
    wait_done(1, 1000);
    check_val("t1_rises", rise_log.size(), 3);
    check_val("t1_falls", fall_log.size(), 3);
    check_val("t1_fc_log_size", fc_log.size(), 3);
    if (fc_log.size() == 3) begin
      for (int i = 0; i < 3; i++) check_val("t1_fc_step", fc_log[i], i + 1);
    end
    if (fall_log.size() == 3) check_val("t1_done_delay", done_cyc - fall_log[2], 1);
    check_val("t1_busy_after", bus.busy, 0);

    // Two frames with a 10-cycle gap
    clear_logs();
    samp_len = 32;
    push_exp(2, 1'b0, 1'b0, 1'b0);
    start_run(32'd4, 16'd2, 32'd10);
    wait_done(2, 500);
    check_val("t2_rises", rise_log.size(), 2);
    if (rise_log.size() >= 1) check_val("t2_first_rise", rise_log[0] - start_cyc, 1);
    if (rise_log.size() >= 2 && fall_log.size() >= 1)
      check_val("t2_gap_delay", rise_log[1] - fall_log[0], 11);

    // Zero frame length rejected, then a valid start clears err_cfg
    clear_logs();
    d0 = done_cnt;
    start_run(32'd0, 16'd1, 32'd0);
    repeat (5) @(negedge adc_clk);
    check_val("t3_err_cfg", bus.err_cfg, 1);
    check_val("t3_busy", bus.busy, 0);
    check_val("t3_no_start", rise_log.size(), 0);
    check_val("t3_no_done", done_cnt, d0);
    samp_len = 5;
    push_exp(1, 1'b0, 1'b0, 1'b0);
    start_run(32'd2, 16'd1, 32'd0);
    check_val("t3_err_cfg_cleared", bus.err_cfg, 0);
    wait_done(3, 200);

    // Sampler never acknowledges
    clear_logs();
    samp_mode = 1;
    push_exp(0, 1'b0, 1'b1, 1'b0);
    start_run(32'd8, 16'd1, 32'd0);
    wait_done(4, 1200);
    check_val("t4_ss_high_cycles", ss_high_cnt, 1024);
    check_val("t4_busy", bus.busy, 0);
    samp_mode = 0;

    // Continuous run aborted while a frame is in flight
    clear_logs();
    samp_len = 20;
    push_exp(3, 1'b0, 1'b0, 1'b1);
    start_run(32'd4, 16'd0, 32'd0);
    wait_falls(2, 200);
    repeat (5) @(posedge adc_clk);
    @(negedge adc_clk);
    bus.cfg_abort = 1'b1;
    @(negedge adc_clk);
    bus.cfg_abort = 1'b0;
    wait_done(5, 200);
    check_val("t5_falls", fall_log.size(), 3);
    if (fall_log.size() == 3) check_val("t5_done_after_fall", done_cyc - fall_log[2], 1);

    // Abort during the gap ends the run on the next edge
    clear_logs();
    samp_len = 8;
    push_exp(1, 1'b0, 1'b0, 1'b1);
    start_run(32'd4, 16'd0, 32'd50);
    wait_falls(1, 200);
    repeat (5) @(posedge adc_clk);
    @(negedge adc_clk);
    bus.cfg_abort = 1'b1;
    d0 = cyc;
    @(negedge adc_clk);
    bus.cfg_abort = 1'b0;
    wait_done(6, 50);
    check_val("t5b_abort_latency", done_cyc - d0, 1);

    // Abort in REQ coinciding with st_clr rising, plus an ignored mid-run start
    clear_logs();
    samp_len = 15;
    push_exp(1, 1'b0, 1'b0, 1'b1);
    start_run(32'd3, 16'd5, 32'd0);
    n = 0;
    while (!bus.sample_start && n < 50) begin
      @(negedge adc_clk);
      n++;
    end
    bus.cfg_abort     = 1'b1;
    bus.cfg_start     = 1'b1;
    bus.cfg_frame_len = 32'd99;
    @(negedge adc_clk);
    bus.cfg_abort     = 1'b0;
    bus.cfg_start     = 1'b0;
    wait_done(7, 100);
    check_val("t6_rises", rise_log.size(), 1);
    if (fall_log.size() >= 1) check_val("t6_done_after_fall", done_cyc - fall_log[0], 1);
    check_val("t6_sample_len_held", bus.sample_len, 3);

    // Reset in the middle of a frame
    clear_logs();
    samp_len = 30;
    d0 = done_cnt;
    start_run(32'd4, 16'd0, 32'd0);
    repeat (10) @(posedge adc_clk);
    @(negedge adc_clk);
    adc_rst = 1'b1;
    @(negedge adc_clk);
    check_val("t7_busy", bus.busy, 0);
    check_val("t7_sample_start", bus.sample_start, 0);
    check_val("t7_frame_cnt", bus.frame_cnt, 0);
    check_val("t7_sample_len", bus.sample_len, 0);
    check_val("t7_aborted", bus.aborted, 0);
    adc_rst = 1'b0;
    repeat (20) @(negedge adc_clk);
    check_val("t7_no_done", done_cnt, d0);
    check_val("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got 1 expected 0");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
